// File: rtl/serial_word_feeder.sv
`timescale 1ns/1ps
// Serial feeder for a downstream bidirectional shift register: accepts a word over
// valid/ready and replays it as WIDTH strobed bits, one bit every DIV clocks.
module serial_word_feeder #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1,
    localparam int CW   = $clog2(WIDTH + 1),
    localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             abort,
    output logic             serial_out,
    output logic             shift_en,
    output logic             dir_out,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    bit_cnt
);

    // Handshake: a word transfers on any rising edge where in_valid && in_ready;
    // in_ready depends on state only, and in_valid is ignored when in_ready is low.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dir_q, dir_d;
    logic             strobe;

    assign strobe = (state_q == S_SHIFT) && (div_cnt_q == DW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            dir_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            dir_q     <= dir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        dir_d     = dir_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shreg_d   = in_data;
                    dir_d     = in_dir;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                end else if (strobe) begin
                    // The bit on serial_out was just taken downstream; expose the next one.
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    shreg_d   = dir_q ? {shreg_q[WIDTH-2:0], 1'b0}
                                      : {1'b0, shreg_q[WIDTH-1:1]};
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_DONE;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (abort) begin
                    bit_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign shift_en   = strobe;
    assign dir_out    = dir_q;
    assign bit_cnt    = bit_cnt_q;
    assign serial_out = (state_q == S_SHIFT) && (dir_q ? shreg_q[WIDTH-1] : shreg_q[0]);

endmodule

// File: tb/tb_serial_word_feeder.sv
`timescale 1ns/1ps
// Bench for serial_word_feeder: a DIV=1 and a DIV=3 instance, a downstream shift
// register model and a queue of expected serial bits popped on every strobe.
module tb_serial_word_feeder;
  localparam int W  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         sel;
  logic         in_valid, abort, in_dir;
  logic [W-1:0] in_data;

  logic          r1, se1, so1, d1, b1, dn1;
  logic [CW-1:0] bc1;
  logic          r3, se3, so3, d3, b3, dn3;
  logic [CW-1:0] bc3;
  logic          v1, v3, a1, a3;

  assign v1 = in_valid & ~sel;
  assign v3 = in_valid & sel;
  assign a1 = abort & ~sel;
  assign a3 = abort & sel;

  serial_word_feeder #(.WIDTH(W), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(in_data),
    .in_dir(in_dir), .abort(a1), .serial_out(so1), .shift_en(se1),
    .dir_out(d1), .busy(b1), .done(dn1), .bit_cnt(bc1)
  );

  serial_word_feeder #(.WIDTH(W), .DIV(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3), .in_data(in_data),
    .in_dir(in_dir), .abort(a3), .serial_out(so3), .shift_en(se3),
    .dir_out(d3), .busy(b3), .done(dn3), .bit_cnt(bc3)
  );

  logic          o_ready, o_se, o_so, o_dir, o_busy, o_done;
  logic [CW-1:0] o_cnt;
  assign o_ready = sel ? r3  : r1;
  assign o_se    = sel ? se3 : se1;
  assign o_so    = sel ? so3 : so1;
  assign o_dir   = sel ? d3  : d1;
  assign o_busy  = sel ? b3  : b1;
  assign o_done  = sel ? dn3 : dn1;
  assign o_cnt   = sel ? bc3 : bc1;

  // Downstream register attached to the selected feeder.
  logic [W-1:0] ds_q;
  always @(posedge clk) begin
    if (o_se) ds_q <= o_dir ? {ds_q[W-2:0], o_so} : {o_so, ds_q[W-1:1]};
  end

  logic exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic run_word(input logic [W-1:0] w, input logic d, input int div,
                          input bit chain, input logic [W-1:0] nw, input logic nd,
                          input bit abort_on_accept);
    int   last;
    int   idx;
    logic exp_bit, exp_se, got;
    last = W * div;
    @(negedge clk);
    vectors++;
    if ({o_ready, o_busy, o_done, o_se, o_so} !== 5'b10000) begin
      errors++;
      $display("FAIL idle_before_accept got %b exp 10000", {o_ready, o_busy, o_done, o_se, o_so});
    end
    in_valid = 1'b1; in_data = w; in_dir = d; abort = abort_on_accept;
    for (int i = 0; i < W; i++) exp_q.push_back(d ? w[W-1-i] : w[i]);
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        abort = 1'b0;
        if (chain) begin
          in_data = nw; in_dir = nd;
        end else begin
          in_valid = 1'b0; in_data = W'($urandom); in_dir = 1'($urandom);
        end
      end
      exp_se = (k <= last) && (k % div == 0);
      vectors++;
      if ({o_ready, o_busy, o_done, o_se} !== {1'b0, 1'b1, (k == last + 1), exp_se}) begin
        errors++;
        $display("FAIL ctrl k=%0d got rdy/busy/done/se=%b exp %b", k,
                 {o_ready, o_busy, o_done, o_se}, {1'b0, 1'b1, (k == last + 1), exp_se});
      end
      vectors++;
      if (o_dir !== d) begin
        errors++;
        $display("FAIL dir_out k=%0d got %b exp %b", k, o_dir, d);
      end
      vectors++;
      if (o_cnt !== ((k <= last) ? CW'((k - 1) / div) : CW'(W))) begin
        errors++;
        $display("FAIL bit_cnt k=%0d got %0d exp %0d", k, o_cnt, (k <= last) ? (k - 1) / div : W);
      end
      if (k <= last) begin
        idx = (k - 1) / div;
        exp_bit = d ? w[W-1-idx] : w[idx];
      end else begin
        exp_bit = 1'b0;
      end
      vectors++;
      if (o_so !== exp_bit) begin
        errors++;
        $display("FAIL serial_out k=%0d got %b exp %b", k, o_so, exp_bit);
      end
      if (o_se === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_strobe k=%0d got strobe exp none", k);
        end else begin
          got = exp_q.pop_front();
          if (o_so !== got) begin
            errors++;
            $display("FAIL strobe_bit k=%0d got %b exp %b", k, o_so, got);
          end
        end
      end
      if (k == last + 1) begin
        vectors++;
        if (ds_q !== w || exp_q.size() != 0) begin
          errors++;
          $display("FAIL downstream got %b (left %0d) exp %b (left 0)", ds_q, exp_q.size(), w);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; abort = 1'b0; in_data = '0; in_dir = 1'b0;
    #12;
    vectors++;
    if ({r1, b1, dn1, se1, so1, d1, bc1} !== {6'b100000, 3'd0}) begin
      errors++;
      $display("FAIL reset_div1 got %b exp 100000000", {r1, b1, dn1, se1, so1, d1, bc1});
    end
    vectors++;
    if ({r3, b3, dn3, se3, so3, d3, bc3} !== {6'b100000, 3'd0}) begin
      errors++;
      $display("FAIL reset_div3 got %b exp 100000000", {r3, b3, dn3, se3, so3, d3, bc3});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_dir_both;
    sel = 1'b0;
    run_word(4'b1011, 1'b1, 1, 1'b0, '0, 1'b0, 1'b0);
    run_word(4'b1011, 1'b0, 1, 1'b0, '0, 1'b0, 1'b0);
    run_word(4'b0101, 1'b0, 1, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_div3;
    sel = 1'b1;
    run_word(4'b0110, 1'b1, 3, 1'b0, '0, 1'b0, 1'b0);
    run_word(4'b1001, 1'b0, 3, 1'b0, '0, 1'b0, 1'b0);
    sel = 1'b0;
  endtask

  task automatic test_back_to_back;
    sel = 1'b0;
    run_word(4'b1100, 1'b1, 1, 1'b1, 4'b0011, 1'b0, 1'b0);
    run_word(4'b0011, 1'b0, 1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_abort;
    int strobes;
    sel = 1'b0; strobes = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b1110; in_dir = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (o_se === 1'b1) strobes++;
      abort = (k == 2);
    end
    vectors++;
    if ({o_ready, o_busy, o_done, o_se, o_so, o_cnt} !== {5'b10000, 3'd0} || strobes != 2) begin
      errors++;
      $display("FAIL abort got state %b strobes %0d exp 10000000 strobes 2",
               {o_ready, o_busy, o_done, o_se, o_so, o_cnt}, strobes);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({o_done, o_se, o_busy} !== 3'b000) begin
        errors++;
        $display("FAIL abort_quiet got done/se/busy=%b exp 000", {o_done, o_se, o_busy});
      end
    end
  endtask

  task automatic test_reset_mid;
    sel = 1'b0;
    exp_q.delete();
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b0111; in_dir = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({o_ready, o_busy, o_done, o_se, o_so, o_dir, o_cnt} !== {6'b100000, 3'd0}) begin
      errors++;
      $display("FAIL reset_mid got %b exp 100000000", {o_ready, o_busy, o_done, o_se, o_so, o_dir, o_cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    run_word(4'b1010, 1'b0, 1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 6; n++) begin
      sel = 1'($urandom_range(0, 1));
      run_word(W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), sel ? 3 : 1,
               1'b0, '0, 1'b0, 1'b0);
    end
    sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_dir_both();
    test_div3();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Upstream driver for the bidirectional shift register.
- Accepts a parallel word and a direction over a valid/ready handshake. Drives serial_in, shift_en and dir so that, after exactly WIDTH strobes, the downstream register holds the accepted word.
- A programmable bit period (DIV clocks per bit) supports slow or multicycle downstream loads.
- Emits a done pulse on completion. Supports a synchronous abort.

Parameters:
- WIDTH, 4, word length and number of bits per transfer; must be ≥2.
- DIV, 1, clock cycles per bit period; must be ≥1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  a word is offered.
- in_ready  output  1  the feeder can accept a word; high only in IDLE.
- in_data  input  WIDTH  word to transfer.
- in_dir  input  1  1 = downstream shifts left (MSB-first), 0 = downstream shifts right (LSB-first).
- abort  input  1  synchronous cancel of the transfer in progress.
- serial_out  output  1  current bit; connects to downstream serial_in.
- shift_en  output  1  one-cycle strobe per bit; connects to downstream shift_en.
- dir_out  output  1  captured direction; connects to downstream dir.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse after the last strobe.
- bit_cnt  output  $clog2(WIDTH+1)  number of strobes issued in the current transfer.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all counters 0.
  - serial_out=0, shift_en=0, dir_out=0, busy=0, done=0, bit_cnt=0.
  - in_ready=1, because it is decoded from IDLE.
- Outputs are Moore: decoded from registered state, counters and the data register only. No combinational path from any input to any output.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge, capture in_data to shreg and in_dir to dir_out; clear div_cnt and bit_cnt; go to SHIFT.
  - abort has no effect in IDLE.
- Cycle numbering: cycle 0 is the accepting edge; cycle k is the k-th clock period after it.
- SHIFT:
  - Occupies cycles 1..WIDTH*DIV.
  - div_cnt counts 0..DIV-1, then wraps.
  - shift_en=1 exactly when div_cnt==DIV-1, i.e. at cycles DIV, 2·DIV, …, WIDTH·DIV.
  - serial_out is stable for the whole bit period.
    - dir_out=1: serial_out=shreg[WIDTH-1]; shreg shifts left after each strobe.
    - dir_out=0: serial_out=shreg[0]; shreg shifts right after each strobe.
  - bit_cnt increments on the edge ending each strobe cycle.
  - After the WIDTH-th strobe, go to DONE.
- DONE:
  - Lasts one cycle (cycle WIDTH·DIV+1).
  - done=1, busy=1, in_ready=0, serial_out=0, shift_en=0.
  - Next edge goes to IDLE; the next word can be accepted at the edge ending cycle WIDTH·DIV+2.
- Correctness invariant: after the WIDTH strobes, a downstream shift register obeying dir_out holds in_data exactly, for both directions.
- abort:
  - Sampled at the edge while in SHIFT or DONE; the next state is IDLE, done is not asserted, bit_cnt is cleared.
  - A strobe already high in the cycle abort is sampled still counts as a valid strobe (Moore outputs).
  - Abort in DONE suppresses nothing (done is already asserted) and returns to IDLE as normal.
- in_valid while busy is ignored; in_data and in_dir changes while busy do not affect the transfer.
- dir_out holds its captured value in IDLE until the next accept.
- serial_out=0 whenever not in SHIFT.
- Reset mid-transfer: immediate return to reset values; a partial downstream word is left as-is; shift_en is low from reset assertion onward.

Test Plan:
- WIDTH=4, DIV=1, accept 4'b1011 with dir=1 → serial_out 1,0,1,1 with shift_en high in cycles 1–4; done in cycle 5; in_ready in cycle 6; attached register q=4'b1011.
- Same word with dir=0 → serial_out 1,1,0,1 (LSB first); dir_out=0; q=4'b1011 after 4 strobes.
- DIV=3, word 4'b0110 with dir=1 → shift_en in cycles 3,6,9,12 only; serial_out constant across each 3-cycle period; done in cycle 13; bit_cnt steps 1..4.
- in_valid held high with two words, DIV=1 → second accepted at the end of cycle 6; in_data changes during busy are ignored; no strobe overlap.
- abort asserted in cycle 2 (after the second strobe sampled), DIV=1 → exactly 2 strobes; IDLE in cycle 3; done never asserted; bit_cnt=0; in_ready=1.
- rst pulsed asynchronously mid-SHIFT → shift_en, busy and done drop immediately; in_ready=1; a fresh transfer after reset completes correctly.
